// File: rtl/snap_pkg.sv
// Shared constants for the counter snapshot FIFO.
// Each FIFO entry is {tag, value}: the tag sits in the MSB, above the sampled value.
package snap_pkg;
    localparam int SNAP_WIDTH   = 8;
    localparam int SNAP_DEPTH   = 4;
    localparam int SNAP_ENTRY_W = SNAP_WIDTH + 1;
    localparam int SNAP_TAG_BIT = SNAP_WIDTH;
endpackage

// File: rtl/snap_fifo_mem.sv
// Register-array storage for the snapshot FIFO.
// It has one synchronous write port and one combinational read port, and every entry resets to zero.
module snap_fifo_mem
    import snap_pkg::*;
#(
    parameter int WIDTH = SNAP_ENTRY_W,
    parameter int DEPTH = SNAP_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/value_snapshot_fifo.sv
// This block snapshots the counter value on a capture strobe, tags each sample with a discontinuity bit and feeds a FWFT FIFO.
// Defining SNAP_DEDUP_EN suppresses untagged captures that repeat the last accepted value.
module value_snapshot_fifo
    import snap_pkg::*;
#(
    parameter int WIDTH = SNAP_WIDTH,
    parameter int DEPTH = SNAP_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    input  logic             capture,
    input  logic             clr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_wrap,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   level,
    output logic             overflow
);

    localparam logic [PTR_W:0] LVL_FULL = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   level_q;
    logic [WIDTH-1:0] prev_value;
    logic             wrap_seen, overflow_q;
    logic             disc, tag, dup, cap_eff, push, pop;
    logic [WIDTH:0]   rdata;

    // A value going backwards means the counter either wrapped or was reset.
    assign disc = (value < prev_value);
    assign tag  = wrap_seen | disc;

`ifdef SNAP_DEDUP_EN
    logic [WIDTH-1:0] last_cap;

    assign dup = (value == last_cap) && !tag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     last_cap <= '0;
        else if (clr)   last_cap <= '0;
        else if (push)  last_cap <= value;
    end
`else
    assign dup = 1'b0;
`endif

    assign empty     = (level_q == '0);
    assign full      = (level_q == LVL_FULL);
    assign out_valid = !empty;
    assign level     = level_q;
    assign overflow  = overflow_q;

    assign cap_eff = capture && !dup;
    assign pop     = out_valid && out_ready && !clr;
    assign push    = cap_eff && (!full || (out_valid && out_ready)) && !clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            prev_value <= '0;
            wrap_seen  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            prev_value <= value;
            if (clr) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                level_q    <= '0;
                wrap_seen  <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   level_q <= level_q + 1'b1;
                    2'b01:   level_q <= level_q - 1'b1;
                    default: level_q <= level_q;
                endcase
                // A dropped capture leaves wrap_seen alone so the next accepted sample still carries the tag.
                if (disc)      wrap_seen <= 1'b1;
                else if (push) wrap_seen <= 1'b0;
                if (cap_eff && full && !(out_valid && out_ready)) overflow_q <= 1'b1;
            end
        end
    end

    snap_fifo_mem #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({tag, value}),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign out_wrap = rdata[WIDTH];
    assign out_data = rdata[WIDTH-1:0];

endmodule

// File: tb/tb_value_snapshot_fifo.sv
// Scoreboard bench for value_snapshot_fifo.
// The stimulus pushes the expected {wrap, data} for each capture, and a negedge monitor checks every popped head against it.
module tb_value_snapshot_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] value = '0;
    logic       capture = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] out_data;
    logic       out_wrap;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       full;
    logic       empty;
    logic [2:0] level;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] sb[$];

    value_snapshot_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .capture   (capture),
        .clr       (clr),
        .out_data  (out_data),
        .out_wrap  (out_wrap),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [7:0] v, input logic exp_wrap, input bit accepted);
        value   = v;
        capture = 1'b1;
        if (accepted) sb.push_back({exp_wrap, v});
        tick();
        capture = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (!empty && n < 12) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        check("drain_empty", empty, 1);
        check("sb_consumed", sb.size(), 0);
    endtask

    // Monitor: an entry is consumed at the next posedge whenever valid and ready are both high here.
    initial begin
        logic [8:0] exp;
        forever begin
            @(negedge clk);
            if (reset && !clr && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_pop", {out_wrap, out_data}, 9'h1ff);
                end else begin
                    exp = sb.pop_front();
                    check("fifo_head", {23'd0, out_wrap, out_data}, {23'd0, exp});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset
        tick(); tick();
        reset = 1'b1;
        tick();
        check("rst_empty", empty, 1);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 8'h00);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_full", full, 0);

        // Basic capture
        value = 8'h10;
        tick();
        cap(8'h10, 1'b0, 1'b1);
        check("basic_valid", out_valid, 1);
        check("basic_data", out_data, 8'h10);
        check("basic_wrap", out_wrap, 0);
        check("basic_level", level, 1);
        drain();

        // Wrap tag
        cap(8'hfe, 1'b0, 1'b1);
        value = 8'hff; tick();
        value = 8'h00; tick();
        value = 8'h01; tick();
        cap(8'h02, 1'b1, 1'b1);
        cap(8'h05, 1'b0, 1'b1);
        check("wrap_level", level, 3);
        drain();

        // Fill and overflow
        cap(8'h30, 1'b0, 1'b1);
        cap(8'h31, 1'b0, 1'b1);
        cap(8'h32, 1'b0, 1'b1);
        cap(8'h33, 1'b0, 1'b1);
        check("fill_full", full, 1);
        check("fill_level", level, 4);
        check("fill_no_ovf", overflow, 0);
        cap(8'h34, 1'b0, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_level", level, 4);
        drain();
        check("ovf_sticky", overflow, 1);

        // clr with level=3 and overflow=1
        cap(8'h38, 1'b0, 1'b1);
        cap(8'h39, 1'b0, 1'b1);
        cap(8'h3a, 1'b0, 1'b1);
        check("preclr_level", level, 3);
        check("preclr_ovf", overflow, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        sb.delete();
        check("clr_level", level, 0);
        check("clr_ovf", overflow, 0);
        check("clr_empty", empty, 1);

        // Full with simultaneous push and pop
        cap(8'h50, 1'b0, 1'b1);
        cap(8'h51, 1'b0, 1'b1);
        cap(8'h52, 1'b0, 1'b1);
        cap(8'h53, 1'b0, 1'b1);
        check("pp_pre_level", level, 4);
        out_ready = 1'b1;
        cap(8'h54, 1'b0, 1'b1);
        out_ready = 1'b0;
        check("pp_level", level, 4);
        check("pp_ovf", overflow, 0);
        check("pp_full", full, 1);
        drain();

        // Async reset between clock edges
        cap(8'h60, 1'b0, 1'b1);
        check("prerst_valid", out_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_level", level, 0);
        check("arst_data", out_data, 8'h00);
        check("arst_empty", empty, 1);
        sb.delete();
        #1 reset = 1'b1;
        tick();

`ifdef SNAP_DEDUP_EN
        value = 8'h20;
        clr   = 1'b1;
        tick();
        clr   = 1'b0;
        cap(8'h20, 1'b0, 1'b1);
        cap(8'h20, 1'b0, 1'b0);
        cap(8'h20, 1'b0, 1'b0);
        check("dedup_level", level, 1);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/value_snapshot_fifo.md
Name: value_snapshot_fifo

Overview:
- Downstream consumer of the 8-bit free-running counter.
- Samples the counter's `value` bus on a `capture` strobe and tags each sample with a discontinuity bit: the counter wrapped or was reset since the previous accepted capture.
- Buffers samples in a small first-word-fall-through FIFO, drained by a valid/ready consumer (monitor/debug port of the pipeline).

Parameters:
- WIDTH, 8, width of the sampled counter value.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- PTR_W, 2, log2(DEPTH); pointer width (level counter is PTR_W+1 bits).

Ports:
- clk  input  1  rising-edge clock, same domain as the counter.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- value  input  WIDTH  counter output being observed.
- capture  input  1  request to snapshot `value` this cycle.
- clr  input  1  synchronous clear: flush FIFO, clear overflow and wrap_seen.
- out_data  output  WIDTH  head-entry value.
- out_wrap  output  1  head-entry discontinuity tag.
- out_valid  output  1  head entry present.
- out_ready  input  1  consumer accepts head when out_valid.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- level  output  PTR_W+1  current entry count, 0..DEPTH.
- overflow  output  1  sticky: a capture was dropped.

Behaviour:
- Reset (reset=0, async):
  - wr_ptr, rd_ptr and level = 0; empty=1, full=0; out_valid=0.
  - overflow=0, wrap_seen=0, prev_value=0.
  - All storage entries = 0, so out_data=0 and out_wrap=0.
- Discontinuity detect:
  - prev_value <= value every cycle.
  - disc = (value < prev_value), unsigned compare; covers both the FF->00 wrap and a mid-run counter reset.
  - wrap_seen sets on disc.
  - wrap_seen clears on an accepted capture, unless disc is also true that same cycle, in which case it stays set.
- Push (accepted capture): capture && (!full || pop).
  - Entry written at wr_ptr = {tag, value} of the current cycle, where tag = wrap_seen | disc.
  - wr_ptr increments, modulo DEPTH.
- Pop: out_valid && out_ready; rd_ptr increments, modulo DEPTH.
- FIFO output:
  - FWFT; out_valid = !empty, combinational from level.
  - out_data/out_wrap are read combinationally from storage at rd_ptr.
- Latency:
  - A capture in cycle N is visible at the output in cycle N+1 when the FIFO was empty.
  - Same-cycle bypass is not provided.
- Level update:
  - push only: +1.
  - pop only: -1.
  - both together, or neither: unchanged.
- Full with simultaneous pop: the push is accepted and level stays at DEPTH.
- Empty with simultaneous capture: push only; the pop is impossible because out_valid=0.
- Overflow:
  - Set when capture && full && !pop.
  - That sample is dropped, and wrap_seen is not cleared by the dropped capture.
  - Cleared only by clr or reset.
- clr:
  - Pointers, level, overflow and wrap_seen go to 0 at the clock edge.
  - clr has priority over push and pop in the same cycle.
  - Storage contents are don't-care after clr.
- Reset mid-operation: all entries are lost and the outputs go to their reset values immediately, without waiting for a clock edge.
- Pointer wrap: pointers roll over DEPTH-1 -> 0; level is the sole full/empty indicator.

Optional Feature:
- Macro: SNAP_DEDUP_EN.
- Defined:
  - An extra register last_cap holds the value of the most recent accepted capture; it resets to 0 and is cleared by clr.
  - A capture is suppressed (no push, no overflow, wrap_seen unchanged) when value == last_cap and tag == 0.
- Undefined: every capture is processed per the rules above, and last_cap is absent.

Decomposition:
- Shared package snap_pkg:
  - Constants SNAP_WIDTH=8 and SNAP_DEPTH=4.
  - Entry width constant SNAP_ENTRY_W = SNAP_WIDTH+1.
  - Entry layout: bit [SNAP_WIDTH] = tag, bits [SNAP_WIDTH-1:0] = value.
- One sub-module, snap_fifo_mem:
  - DEPTH x (WIDTH+1) register array with async reset to 0.
  - One write port (we, waddr, wdata), one combinational read port (raddr, rdata).
- The top level holds pointers, level, discontinuity logic, overflow and the optional dedup.

Test Plan:
- Reset sequence: reset=0 for 2 cycles, then 1 -> empty=1, out_valid=0, out_data=0, level=0, overflow=0.
- Basic capture: counter at 0x10, capture 1 cycle, out_ready=0 -> next cycle out_valid=1, out_data=0x10, out_wrap=0, level=1.
- Wrap tag: captures at 0xFE, then 0x02 after the counter passes 0xFF->0x00 -> second entry has out_wrap=1; a next capture at 0x05 has out_wrap=0.
- Fill and overflow, out_ready=0:
  - 4 captures -> full=1, level=4.
  - 5th capture -> overflow=1, level stays 4.
  - Drain yields only the first 4 values, in order.
- Full with simultaneous push+pop: level=4, capture and out_ready both 1 -> level=4, overflow=0, new value appears after 3 further pops.
- clr and async reset: with level=3 and overflow=1, pulse clr -> level=0, overflow=0. Separately, assert reset between clock edges -> outputs reach reset values before the next edge.
- SNAP_DEDUP_EN (when enabled): counter held at 0x20, capture on 3 consecutive cycles -> level=1.
